// File: rtl/gpc_sum_accumulator.sv
// ============================================================================
// gpc_sum_accumulator
// ----------------------------------------------------------------------------
// Frame-level accumulator that sits downstream of the gpc3031_5 compressor.
// Each input beat carries one 5-bit compressor result (0..31). Beats are summed
// into a frame total, and the number of beats in the frame is counted. When the
// last beat of a frame arrives, the registered total, beat count and overflow
// flag are presented on an output valid/ready handshake. They are held there
// until the downstream side accepts them.
//
// Neither the total nor the count ever wraps. A sum or count that exceeds its
// width clamps to all-ones. The overflow flag records that a clamp happened at
// some point in the frame.
//
// Parameters
//   ACC_W     accumulator / out_sum width in bits (>= 5)
//   CNT_W     beat counter / out_cnt width in bits (>= 1)
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   active-low reset; asserts asynchronously, releases
//                   synchronously to clk
//   in_valid   in   in_dst / in_last are valid
//   in_ready   out  block can accept a beat (ACC state and no flush)
//   in_dst     in   [4:0] compressor result, unsigned 0..31
//   in_last    in   beat is the final one of the current frame
//   flush      in   synchronous abort of the partial frame (ignored in HOLD)
//   out_valid  out  out_sum / out_cnt / out_ovf are valid
//   out_ready  in   downstream accepts the presented result
//   out_sum    out  [ACC_W-1:0] saturated frame total
//   out_cnt    out  [CNT_W-1:0] saturated beat count of the frame
//   out_ovf    out  total or count saturated somewhere in the frame
// ============================================================================
module gpc_sum_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_dst,
    input  logic             in_last,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    // ACC collects beats. HOLD presents a finished result and waits for it to
    // be taken.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Reset synchroniser: it asserts immediately with rst_n and releases two
    // clk edges later. This keeps the release of the main register bank
    // aligned to the clock.
    logic [1:0]         r_rst_sync;
    logic               w_rst_n;

    // Running frame state
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    // Presented result
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_out_ovf;

    // Next-state values from the combinational process
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;
    logic               w_out_valid_nxt;
    logic [ACC_W-1:0]   w_out_sum_nxt;
    logic [CNT_W-1:0]   w_out_cnt_nxt;
    logic               w_out_ovf_nxt;

    // Handshake and arithmetic helpers
    logic               w_in_ready;
    logic               w_accept;
    logic [ACC_W:0]     w_sum_wide;
    logic               w_sum_sat;
    logic [ACC_W-1:0]   w_sum_clamped;
    logic               w_cnt_sat;
    logic [CNT_W-1:0]   w_cnt_clamped;

    // ------------------------------------------------------------------------
    // Reset release synchroniser
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------------
    // in_ready depends only on registered state and flush. It never depends
    // on out_ready. So after a HOLD ends, the next beat is taken one cycle
    // later, not in the same cycle.
    assign w_in_ready = (r_state == ST_ACC) && !flush;
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------------
    // Saturating arithmetic
    // ------------------------------------------------------------------------
    // The sum is formed one bit wider than the accumulator. A carry into the
    // top bit means the true sum would not fit, so the result clamps to
    // all-ones.
    assign w_sum_wide    = {1'b0, r_acc} + {{(ACC_W - 4){1'b0}}, in_dst};
    assign w_sum_sat     = w_sum_wide[ACC_W];
    assign w_sum_clamped = w_sum_sat ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];

    // The counter stops at all-ones. Trying to step past that is the count
    // saturation event.
    assign w_cnt_sat     = (r_cnt == {CNT_W{1'b1}});
    assign w_cnt_clamped = w_cnt_sat ? r_cnt : r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------------
    // By default every register holds its value. Only the cases below move
    // anything.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_cnt_nxt   = r_out_cnt;
        w_out_ovf_nxt   = r_out_ovf;

        unique case (r_state)
            ST_ACC: begin
                if (flush) begin
                    // Drop the partial frame. Any beat offered this cycle is
                    // refused, because in_ready is low.
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b0;
                end else if (w_accept) begin
                    if (in_last) begin
                        // Close the frame. Publish the result and start the
                        // next frame from zero.
                        w_out_sum_nxt   = w_sum_clamped;
                        w_out_cnt_nxt   = w_cnt_clamped;
                        w_out_ovf_nxt   = r_ovf || w_sum_sat || w_cnt_sat;
                        w_out_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_ovf_nxt       = 1'b0;
                        w_state_nxt     = ST_HOLD;
                    end else begin
                        w_acc_nxt = w_sum_clamped;
                        w_cnt_nxt = w_cnt_clamped;
                        w_ovf_nxt = r_ovf || w_sum_sat || w_cnt_sat;
                    end
                end
            end

            ST_HOLD: begin
                // flush is ignored here, so the pending result survives.
                // The published values also stay in place after out_valid
                // drops.
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_ACC;
                end
            end

            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_gpc_sum_accumulator.sv
// ============================================================================
// tb_gpc_sum_accumulator
// ----------------------------------------------------------------------------
// Drives two accumulator instances from the same stimulus:
//   - instance A uses the default sizes (ACC_W=16, CNT_W=10);
//   - instance B uses narrow sizes (ACC_W=8, CNT_W=4), so sum and count
//     saturation are easy to reach.
// Expected results come from whole-frame arithmetic. The true frame total and
// beat count are clamped to each instance's maximum. Overflow is flagged when
// either true value exceeds that maximum.
// ============================================================================
module tb_gpc_sum_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_dst;
    logic        in_last;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_sum;
    logic [9:0]  a_out_cnt;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_out_sum;
    logic [3:0]  b_out_cnt;

    int nVec = 0;
    int nErr = 0;

    gpc_sum_accumulator #(.ACC_W(16), .CNT_W(10)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_dst(in_dst), .in_last(in_last), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
    );

    gpc_sum_accumulator #(.ACC_W(8), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_dst(in_dst), .in_last(in_last), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference results for A: {sum16, cnt10, ovf}
    function automatic logic [26:0] expA(input int total, input int n);
        int s;
        int c;
        s = (total > 65535) ? 65535 : total;
        c = (n > 1023) ? 1023 : n;
        return {s[15:0], c[9:0], (total > 65535) || (n > 1023)};
    endfunction

    // Reference results for B: {sum8, cnt4, ovf}
    function automatic logic [12:0] expB(input int total, input int n);
        int s;
        int c;
        s = (total > 255) ? 255 : total;
        c = (n > 15) ? 15 : n;
        return {s[7:0], c[3:0], (total > 255) || (n > 15)};
    endfunction

    // Inputs are applied just after a falling edge and settle before the
    // checks that follow.
    task automatic setIn(input bit v, input logic [4:0] d, input bit l,
                         input bit f, input bit r);
        in_valid  = v;
        in_dst    = d;
        in_last   = l;
        flush     = f;
        out_ready = r;
        #1;
    endtask

    // Advance one full cycle. The rising edge falls in between, and we return
    // on the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIn(0, 5'd0, 0, 0, 1);
        tick();
        tick();
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== 28'd0 ||
            {b_out_valid, b_out_sum, b_out_cnt, b_out_ovf} !== 14'd0) begin
            nErr++;
            $display("[TB] FAIL reset_outputs: A=%h B=%h required 0", {a_out_valid, a_out_sum, a_out_cnt, a_out_ovf}, {b_out_valid, b_out_sum, b_out_cnt, b_out_ovf});
        end
        #2 rst_n = 1'b1;
        tick();
        tick();
        tick();
        nVec++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL reset_idle: rdyA=%b rdyB=%b vldA=%b required 1 1 0", a_in_ready, b_in_ready, a_out_valid);
        end
    endtask

    task automatic test_basic_frame();
        setIn(1, 5'd31, 0, 0, 1);
        tick();
        setIn(1, 5'd31, 0, 0, 1);
        tick();
        setIn(1, 5'd5, 1, 0, 1);
        nVec++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL basic_pre: vld=%b rdy=%b required 0 1", a_out_valid, a_in_ready);
        end
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== {1'b1, 16'd67, 10'd3, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL basic_A: got v%b s%0d c%0d o%b required v1 s67 c3 o0", a_out_valid, a_out_sum, a_out_cnt, a_out_ovf);
        end
        nVec++;
        if ({b_out_valid, b_out_sum, b_out_cnt, b_out_ovf} !== {1'b1, expB(67, 3)}) begin
            nErr++;
            $display("[TB] FAIL basic_B: got v%b s%0d c%0d o%b required v1 %h", b_out_valid, b_out_sum, b_out_cnt, b_out_ovf, expB(67, 3));
        end
        tick();
        nVec++;
        if (a_out_valid !== 1'b0 || a_out_sum !== 16'd67) begin
            nErr++;
            $display("[TB] FAIL basic_pulse: vld=%b sum=%0d required 0 67", a_out_valid, a_out_sum);
        end
    endtask

    task automatic test_single_beat();
        setIn(1, 5'h07, 1, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== {1'b1, 16'd7, 10'd1, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL single_A: got v%b s%0d c%0d o%b required v1 s7 c1 o0", a_out_valid, a_out_sum, a_out_cnt, a_out_ovf);
        end
        tick();
        setIn(1, 5'h1F, 0, 0, 1);
        tick();
        setIn(1, 5'h01, 1, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== {1'b1, 16'd32, 10'd2, 1'b0} ||
            {b_out_sum, b_out_cnt, b_out_ovf} !== expB(32, 2)) begin
            nErr++;
            $display("[TB] FAIL second_frame: A s%0d c%0d B s%0d c%0d required s32 c2", a_out_sum, a_out_cnt, b_out_sum, b_out_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        setIn(1, 5'd4, 0, 0, 0);
        tick();
        setIn(1, 5'd6, 1, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            setIn(1, 5'd9, 1, 0, 0);
            nVec++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_sum !== 16'd10 || a_out_cnt !== 10'd2) begin
                nErr++;
                $display("[TB] FAIL hold_cycle%0d: rdy=%b vld=%b sum=%0d cnt=%0d required 0 1 10 2", i, a_in_ready, a_out_valid, a_out_sum, a_out_cnt);
            end
            tick();
        end
        setIn(1, 5'd9, 1, 0, 1);
        tick();
        nVec++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_sum !== 16'd10) begin
            nErr++;
            $display("[TB] FAIL release: vld=%b rdy=%b sum=%0d required 0 1 10", a_out_valid, a_in_ready, a_out_sum);
        end
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt} !== {1'b1, 16'd9, 10'd1}) begin
            nErr++;
            $display("[TB] FAIL pending_beat: v%b s%0d c%0d required v1 s9 c1", a_out_valid, a_out_sum, a_out_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            setIn(1, 5'd31, i == 8, 0, 1);
            tick();
        end
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({b_out_valid, b_out_sum, b_out_cnt, b_out_ovf} !== {1'b1, 8'd255, 4'd9, 1'b1}) begin
            nErr++;
            $display("[TB] FAIL sat_B: v%b s%0d c%0d o%b required v1 s255 c9 o1", b_out_valid, b_out_sum, b_out_cnt, b_out_ovf);
        end
        nVec++;
        if ({a_out_sum, a_out_cnt, a_out_ovf} !== expA(279, 9)) begin
            nErr++;
            $display("[TB] FAIL sat_A: s%0d c%0d o%b required s279 c9 o0", a_out_sum, a_out_cnt, a_out_ovf);
        end
        tick();
        setIn(1, 5'd3, 1, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({b_out_valid, b_out_sum, b_out_cnt, b_out_ovf} !== {1'b1, 8'd3, 4'd1, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL sat_clear: v%b s%0d c%0d o%b required v1 s3 c1 o0", b_out_valid, b_out_sum, b_out_cnt, b_out_ovf);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            setIn(1, 5'd1, i == 19, 0, 1);
            tick();
        end
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({b_out_sum, b_out_cnt, b_out_ovf} !== {8'd20, 4'd15, 1'b1} ||
            {a_out_sum, a_out_cnt, a_out_ovf} !== {16'd20, 10'd20, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL cnt_sat: B s%0d c%0d o%b A c%0d o%b required B s20 c15 o1 A c20 o0", b_out_sum, b_out_cnt, b_out_ovf, a_out_cnt, a_out_ovf);
        end
        tick();
    endtask

    task automatic test_flush();
        setIn(1, 5'd20, 0, 0, 1);
        tick();
        setIn(1, 5'd20, 0, 0, 1);
        tick();
        setIn(1, 5'd9, 0, 1, 1);
        nVec++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL flush_ready: A=%b B=%b required 0", a_in_ready, b_in_ready);
        end
        tick();
        setIn(1, 5'd4, 1, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== {1'b1, 16'd4, 10'd1, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL flush_frame: v%b s%0d c%0d o%b required v1 s4 c1 o0", a_out_valid, a_out_sum, a_out_cnt, a_out_ovf);
        end
        tick();
        setIn(1, 5'd11, 0, 0, 0);
        tick();
        setIn(1, 5'd2, 1, 0, 0);
        tick();
        setIn(0, 5'd0, 0, 1, 0);
        tick();
        tick();
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt} !== {1'b1, 16'd13, 10'd2}) begin
            nErr++;
            $display("[TB] FAIL flush_hold: v%b s%0d c%0d required v1 s13 c2", a_out_valid, a_out_sum, a_out_cnt);
        end
        setIn(0, 5'd0, 0, 0, 1);
        tick();
        setIn(1, 5'd5, 1, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt} !== {1'b1, 16'd5, 10'd1}) begin
            nErr++;
            $display("[TB] FAIL after_hold: v%b s%0d c%0d required v1 s5 c1", a_out_valid, a_out_sum, a_out_cnt);
        end
        tick();
    endtask

    task automatic test_async_reset();
        setIn(1, 5'd15, 0, 0, 1);
        tick();
        setIn(1, 5'd15, 0, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== 28'd0 ||
            {b_out_sum, b_out_cnt, b_out_ovf} !== 13'd0) begin
            nErr++;
            $display("[TB] FAIL async_reset: A s%0d c%0d B s%0d required 0", a_out_sum, a_out_cnt, b_out_sum);
        end
        #1 rst_n = 1'b1;
        tick();
        tick();
        tick();
        setIn(1, 5'd6, 1, 0, 1);
        tick();
        setIn(0, 5'd0, 0, 0, 1);
        nVec++;
        if ({a_out_valid, a_out_sum, a_out_cnt, a_out_ovf} !== {1'b1, 16'd6, 10'd1, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL post_reset: v%b s%0d c%0d o%b required v1 s6 c1 o0", a_out_valid, a_out_sum, a_out_cnt, a_out_ovf);
        end
        tick();
    endtask

    // Random traffic checked cycle by cycle against a frame-level model.
    // Only the pending flag, the true running total and the beat count are
    // tracked.
    task automatic test_random();
        bit          pend;
        int          tot;
        int          n;
        logic [26:0] lastA;
        logic [12:0] lastB;
        bit          v, l, f, r, expRdy;
        logic [4:0]  d;
        pend  = 1'b0;
        tot   = 0;
        n     = 0;
        lastA = expA(6, 1);
        lastB = expB(6, 1);
        for (int c = 0; c < 1500; c++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 5'($urandom_range(0, 31));
            l = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 2) != 0);
            setIn(v, d, l, f, r);
            expRdy = !pend && !f;
            nVec++;
            if (a_in_ready !== expRdy || b_in_ready !== expRdy ||
                a_out_valid !== pend || b_out_valid !== pend) begin
                nErr++;
                $display("[TB] FAIL rnd_hs c%0d: rdy %b/%b vld %b/%b required rdy %b vld %b", c, a_in_ready, b_in_ready, a_out_valid, b_out_valid, expRdy, pend);
            end
            nVec++;
            if ({a_out_sum, a_out_cnt, a_out_ovf} !== lastA || {b_out_sum, b_out_cnt, b_out_ovf} !== lastB) begin
                nErr++;
                $display("[TB] FAIL rnd_data c%0d: A=%h B=%h required A=%h B=%h", c, {a_out_sum, a_out_cnt, a_out_ovf}, {b_out_sum, b_out_cnt, b_out_ovf}, lastA, lastB);
            end
            if (pend) begin
                if (r) pend = 1'b0;
            end else if (f) begin
                tot = 0;
                n   = 0;
            end else if (v) begin
                tot = tot + int'(d);
                n   = n + 1;
                if (l) begin
                    lastA = expA(tot, n);
                    lastB = expB(tot, n);
                    pend  = 1'b1;
                    tot   = 0;
                    n     = 0;
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dst    = 5'd0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_single_beat();
        test_back_to_back();
        test_saturation();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/gpc_sum_accumulator.md
Name: gpc_sum_accumulator

Overview:
- Downstream consumer of the gpc3031_5 compressor: accepts a stream of its 5-bit dst results (weighted sum of src0 x1, src1 x2, src3 x8; range 0..31) over a valid/ready handshake.
- Accumulates them into a frame total and presents the registered total, beat count and overflow flag on an output handshake.
- Closes the compressor-tree stage for frame-level popcount/weighted-sum use.

Parameters:
- ACC_W, 16, accumulator and out_sum width in bits (>= 5).
- CNT_W, 10, beat-counter and out_cnt width in bits (>= 1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  in_dst/in_last valid.
- in_ready  output  1  block can accept a beat.
- in_dst  input  5  gpc3031_5 dst value, unsigned 0..31.
- in_last  input  1  final beat of the current frame.
- flush  input  1  synchronous abort of the partial frame.
- out_valid  output  1  out_sum/out_cnt/out_ovf valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  frame total, saturated.
- out_cnt  output  CNT_W  beats in frame, saturated.
- out_ovf  output  1  total or count saturated in this frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACC; acc, cnt, ovf cleared.
  - out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - Release is synchronised to clk.
- States:
  - ACC: accumulating.
  - HOLD: result presented, awaiting out_ready.
- Input handshake:
  - in_ready = (state==ACC) && !flush.
  - A beat is accepted when in_valid && in_ready at a clk edge.
- Accepted beat, in ACC with in_last=0:
  - acc <= sat(acc + in_dst); cnt <= sat(cnt + 1).
  - ovf is set sticky if either saturates.
- Accepted beat with in_last=1:
  - out_sum <= sat(acc + in_dst); out_cnt <= sat(cnt + 1).
  - out_ovf <= ovf OR saturation on this beat.
  - out_valid <= 1; acc, cnt, ovf cleared; state -> HOLD.
  - Latency: result visible exactly 1 cycle after the last-beat edge.
- Arithmetic:
  - Sums computed at ACC_W+1 bits.
  - Any result > 2^ACC_W-1 clamps to all-ones.
  - cnt clamps at 2^CNT_W-1.
  - No wrap-around ever.
- HOLD:
  - out_* held stable, in_ready=0.
  - On out_valid && out_ready: out_valid <= 0, state -> ACC. New beats are accepted from the following cycle (no combinational out_ready->in_ready path).
  - out_sum/out_cnt/out_ovf keep their last values after out_valid drops.
- flush:
  - In ACC: acc, cnt, ovf cleared next edge; any beat presented that cycle is not accepted (in_ready=0).
  - In HOLD: ignored; the pending result is preserved.
- Single-beat frame (in_last on the first beat): out_cnt=1, out_sum=in_dst.
- Reset mid-frame or in HOLD: partial or pending result is lost; outputs return to reset values.
- X on in_dst while in_valid=0 must not affect state.

Test Plan:
- Frame in_dst=31,31,5 (last on 3rd), out_ready=1 -> out_valid one cycle after 3rd accept, out_sum=67, out_cnt=3, out_ovf=0; out_valid high exactly 1 cycle.
- Single beat in_dst=0x07 with in_last=1 -> out_sum=7, out_cnt=1; next frame 0x1F,0x01 -> out_sum=32, out_cnt=2 (no carry-over from prior frame).
- Backpressure: complete frame (sum 10), hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_sum=10 stable; out_ready=1 -> out_valid drops next cycle, in_ready=1 that cycle, pending input beat accepted.
- Saturation (ACC_W=8): 9 beats of 31, last on 9th -> out_sum=255, out_cnt=9, out_ovf=1; following frame of one beat 3 -> out_ovf=0, out_sum=3.
- Flush: beats 20,20, then flush with in_valid=1, in_dst=9 -> beat not accepted; then beat 4 with last -> out_sum=4, out_cnt=1. Flush during HOLD -> pending result unchanged.
- Async reset mid-frame after beats 15,15, asserted between edges -> outputs 0 immediately; after release, frame 6(last) -> out_sum=6, out_cnt=1.
